// File: rtl/fb_pkg.sv
// Frame-buffer types and sizes shared by the UART-side writer and the pixel-clock readers.
package fb_pkg;

    localparam int unsigned FB_ADDR_W = 18;
    localparam int unsigned FB_PIXELS = 76800;
    localparam int unsigned FB_DATA_W = 24;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        WAIT_R = 2'd0,
        WAIT_G = 2'd1,
        WAIT_B = 2'd2
    } load_state_t;

endpackage

// File: rtl/image_loader_if.sv
// Byte stream in, BRAM port-A write bus and status out for the image loader.
interface image_loader_if import fb_pkg::*; #(
    parameter int unsigned ADDR_W = FB_ADDR_W
);
    logic                 rx_ready;
    logic [7:0]           rx_data;
    logic                 frame_restart;
    logic                 bram_we;
    logic [ADDR_W-1:0]    bram_addr;
    logic [FB_DATA_W-1:0] bram_din;
    logic                 frame_done;
    logic                 busy;
    logic                 resync_err;

    modport master (
        output rx_ready, rx_data, frame_restart,
        input  bram_we, bram_addr, bram_din, frame_done, busy, resync_err
    );

    modport slave (
        input  rx_ready, rx_data, frame_restart,
        output bram_we, bram_addr, bram_din, frame_done, busy, resync_err
    );
endinterface

// File: rtl/byte_timeout.sv
// Idle counter: runs while enabled, clears on i_clr, flags the edge on which it reaches the limit.
module byte_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire_c
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;

    // Saturating count; held at zero whenever disabled.
    always_ff @(posedge clk) begin
        if (!rst_n || i_clr || !i_en) begin
            r_cnt <= '0;
        end else if (r_cnt != CNT_W'(TIMEOUT_CYCLES)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_expire_c = i_en && !i_clr && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/image_loader.sv
// Assembles R,G,B UART bytes into 24-bit pixels and writes them to sequential BRAM addresses.
module image_loader import fb_pkg::*; #(
    parameter int unsigned ADDR_W         = FB_ADDR_W,
    parameter int unsigned PIXELS         = FB_PIXELS,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic           CLK100MHZ,
    input  logic           CPU_RESETN,
    image_loader_if.slave  bus
);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(PIXELS - 1);

    load_state_t       r_state;
    load_state_t       w_state_nxt;
    logic              w_latch_r;
    logic              w_latch_g;
    logic              w_write;
    logic              w_resync;
    logic              w_expire;
    logic              w_busy;

    logic [7:0]        r_r;
    logic [7:0]        r_g;
    logic [ADDR_W-1:0] r_idx;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    rgb_t              r_din;
    logic              r_done;
    logic              r_resync;

    assign w_busy = (r_state != WAIT_R);

    byte_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk        (CLK100MHZ),
        .rst_n      (CPU_RESETN),
        .i_clr      (bus.rx_ready || bus.frame_restart),
        .i_en       (w_busy),
        .o_expire_c (w_expire)
    );

    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) r_state <= WAIT_R;
        else             r_state <= w_state_nxt;
    end

    // Precedence: frame_restart, then byte arrival, then timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_latch_r   = 1'b0;
        w_latch_g   = 1'b0;
        w_write     = 1'b0;
        w_resync    = 1'b0;
        if (bus.frame_restart) begin
            w_state_nxt = WAIT_R;
        end else if (bus.rx_ready) begin
            unique case (r_state)
                WAIT_R: begin w_latch_r = 1'b1; w_state_nxt = WAIT_G; end
                WAIT_G: begin w_latch_g = 1'b1; w_state_nxt = WAIT_B; end
                WAIT_B: begin w_write   = 1'b1; w_state_nxt = WAIT_R; end
                default:        w_state_nxt = WAIT_R;
            endcase
        end else if (w_expire) begin
            w_state_nxt = WAIT_R;
            w_resync    = 1'b1;
        end
    end

    // Colour latches, pixel index and the registered write port.
    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            r_r      <= '0;
            r_g      <= '0;
            r_idx    <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_din    <= '0;
            r_done   <= 1'b0;
            r_resync <= 1'b0;
        end else begin
            r_we     <= w_write;
            r_done   <= w_write && (r_idx == LAST_IDX);
            r_resync <= w_resync;
            if (w_latch_r) r_r <= bus.rx_data;
            if (w_latch_g) r_g <= bus.rx_data;
            if (bus.frame_restart) begin
                r_idx <= '0;
            end else if (w_write) begin
                r_addr <= r_idx;
                r_din  <= '{r: r_r, g: r_g, b: bus.rx_data};
                r_idx  <= (r_idx == LAST_IDX) ? '0 : r_idx + ADDR_W'(1);
            end
        end
    end

    assign bus.bram_we    = r_we;
    assign bus.bram_addr  = r_addr;
    assign bus.bram_din   = r_din;
    assign bus.frame_done = r_done;
    assign bus.busy       = w_busy;
    assign bus.resync_err = r_resync;
endmodule

// File: tb/tb_image_loader.sv
// Directed bench: dut_a (4-pixel frame) and dut_b (16-pixel frame) share one stimulus stream.
module tb_image_loader;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       frame_restart = 1'b0;
    int         n_pass = 0;
    int         n_tot = 0;

    always #5 clk = ~clk;

    image_loader_if #(.ADDR_W(8)) if_a ();
    image_loader_if #(.ADDR_W(8)) if_b ();

    assign if_a.rx_ready      = rx_ready;
    assign if_a.rx_data       = rx_data;
    assign if_a.frame_restart = frame_restart;
    assign if_b.rx_ready      = rx_ready;
    assign if_b.rx_data       = rx_data;
    assign if_b.frame_restart = frame_restart;

    image_loader #(.ADDR_W(8), .PIXELS(4), .TIMEOUT_CYCLES(16)) dut_a (
        .CLK100MHZ (clk),
        .CPU_RESETN(rst_n),
        .bus       (if_a)
    );

    image_loader #(.ADDR_W(8), .PIXELS(16), .TIMEOUT_CYCLES(16)) dut_b (
        .CLK100MHZ (clk),
        .CPU_RESETN(rst_n),
        .bus       (if_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] b);
        rx_ready = 1'b1;
        rx_data  = b;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic chk_all_zero_a(input string tag);
        chk({tag, "_a_we"},   32'(if_a.bram_we),    32'h0);
        chk({tag, "_a_addr"}, 32'(if_a.bram_addr),  32'h0);
        chk({tag, "_a_din"},  32'(if_a.bram_din),   32'h0);
        chk({tag, "_a_done"}, 32'(if_a.frame_done), 32'h0);
        chk({tag, "_a_busy"}, 32'(if_a.busy),       32'h0);
        chk({tag, "_a_rerr"}, 32'(if_a.resync_err), 32'h0);
    endtask

    task automatic chk_all_zero_b(input string tag);
        chk({tag, "_b_we"},   32'(if_b.bram_we),    32'h0);
        chk({tag, "_b_addr"}, 32'(if_b.bram_addr),  32'h0);
        chk({tag, "_b_din"},  32'(if_b.bram_din),   32'h0);
        chk({tag, "_b_done"}, 32'(if_b.frame_done), 32'h0);
        chk({tag, "_b_busy"}, 32'(if_b.busy),       32'h0);
        chk({tag, "_b_rerr"}, 32'(if_b.resync_err), 32'h0);
    endtask

    initial begin
        // Reset values
        tick();
        do_reset();
        chk_all_zero_a("rst");
        chk_all_zero_b("rst");

        // Two basic pixels on dut_b
        send(8'h12);
        chk("p0_busy_r", 32'(if_b.busy), 32'h1);
        chk("p0_we_r",   32'(if_b.bram_we), 32'h0);
        send(8'h34);
        chk("p0_busy_g", 32'(if_b.busy), 32'h1);
        send(8'h56);
        chk("p0_we",   32'(if_b.bram_we),   32'h1);
        chk("p0_addr", 32'(if_b.bram_addr), 32'h0);
        chk("p0_din",  32'(if_b.bram_din),  32'h123456);
        chk("p0_busy", 32'(if_b.busy),      32'h0);
        chk("p0_done", 32'(if_b.frame_done), 32'h0);
        tick();
        chk("p0_we_off",   32'(if_b.bram_we),  32'h0);
        chk("p0_din_hold", 32'(if_b.bram_din), 32'h123456);
        send(8'hAA);
        send(8'hBB);
        send(8'hCC);
        chk("p1_we",   32'(if_b.bram_we),   32'h1);
        chk("p1_addr", 32'(if_b.bram_addr), 32'h1);
        chk("p1_din",  32'(if_b.bram_din),  32'hAABBCC);

        // Full 4-pixel frame on dut_a, back-to-back bytes
        do_reset();
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 3; k++) begin
                send(8'(16 * p + k));
                if (k < 2) begin
                    chk("fr_we_mid",   32'(if_a.bram_we),    32'h0);
                    chk("fr_done_mid", 32'(if_a.frame_done), 32'h0);
                end
            end
            chk("fr_we",   32'(if_a.bram_we),    32'h1);
            chk("fr_addr", 32'(if_a.bram_addr),  32'(p));
            chk("fr_din",  32'(if_a.bram_din),   32'(((16 * p) << 16) | ((16 * p + 1) << 8) | (16 * p + 2)));
            chk("fr_done", 32'(if_a.frame_done), (p == 3) ? 32'h1 : 32'h0);
        end
        send(8'h01);
        send(8'h02);
        send(8'h03);
        chk("wrap_addr", 32'(if_a.bram_addr),  32'h0);
        chk("wrap_we",   32'(if_a.bram_we),    32'h1);
        chk("wrap_done", 32'(if_a.frame_done), 32'h0);

        // Timeout drops a partial pixel after 16 idle cycles
        do_reset();
        send(8'h01);
        send(8'h02);
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("to_early_rerr", 32'(if_a.resync_err), 32'h0);
            chk("to_early_busy", 32'(if_a.busy),       32'h1);
        end
        tick();
        chk("to_rerr", 32'(if_a.resync_err), 32'h1);
        chk("to_busy", 32'(if_a.busy),       32'h0);
        chk("to_we",   32'(if_a.bram_we),    32'h0);
        tick();
        chk("to_rerr_off", 32'(if_a.resync_err), 32'h0);
        send(8'h10);
        send(8'h20);
        send(8'h30);
        chk("to_next_we",   32'(if_a.bram_we),   32'h1);
        chk("to_next_addr", 32'(if_a.bram_addr), 32'h0);
        chk("to_next_din",  32'(if_a.bram_din),  32'h102030);

        // Byte on the exact expiry cycle wins over the timeout
        do_reset();
        send(8'h01);
        send(8'h02);
        for (int i = 1; i < 16; i++) tick();
        send(8'h03);
        chk("edge_rerr", 32'(if_a.resync_err), 32'h0);
        chk("edge_we",   32'(if_a.bram_we),    32'h1);
        chk("edge_din",  32'(if_a.bram_din),   32'h010203);
        tick();
        chk("edge_rerr2", 32'(if_a.resync_err), 32'h0);

        // frame_restart with a simultaneous byte, on dut_b
        do_reset();
        for (int i = 0; i < 16; i++) send(8'(i + 8'h40));
        chk("rs_busy_pre", 32'(if_b.busy),      32'h1);
        chk("rs_addr_pre", 32'(if_b.bram_addr), 32'h4);
        rx_ready      = 1'b1;
        rx_data       = 8'h77;
        frame_restart = 1'b1;
        tick();
        rx_ready      = 1'b0;
        frame_restart = 1'b0;
        chk("rs_busy", 32'(if_b.busy),      32'h0);
        chk("rs_we",   32'(if_b.bram_we),   32'h0);
        chk("rs_addr_hold", 32'(if_b.bram_addr), 32'h4);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        chk("rs_addr", 32'(if_b.bram_addr), 32'h0);
        chk("rs_din",  32'(if_b.bram_din),  32'h112233);

        // Reset mid-pixel at index 7 on dut_b
        do_reset();
        for (int i = 0; i < 22; i++) send(8'(i));
        chk("mr_addr_pre", 32'(if_b.bram_addr), 32'h6);
        chk("mr_busy_pre", 32'(if_b.busy),      32'h1);
        rst_n = 1'b0;
        tick();
        chk_all_zero_b("mr");
        rst_n = 1'b1;
        tick();
        chk("mr_rerr", 32'(if_b.resync_err), 32'h0);
        send(8'hDE);
        send(8'hAD);
        send(8'hBE);
        chk("mr_we",   32'(if_b.bram_we),   32'h1);
        chk("mr_addr", 32'(if_b.bram_addr), 32'h0);
        chk("mr_din",  32'(if_b.bram_din),  32'hDEADBE);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/image_loader.md
# image_loader

Write-side front end of the frame buffer: assembles 8-bit UART receive bytes into 24-bit RGB pixels and drives the BRAM write port (port A, 100 MHz domain) that the pixel-clock readers consume on port B. Each complete pixel produces exactly one write strobe at a sequentially incremented address. A full frame produces a completion pulse. An inter-byte timeout discards partial pixels so the stream resynchronises.

## Interface
Parameters:
- ADDR_W, 18, BRAM port-A address width
- PIXELS, 76800, pixels per frame (320x240); legal range 1..2**ADDR_W
- TIMEOUT_CYCLES, 1000000, idle clocks allowed between bytes of one pixel (10 ms @ 100 MHz)

Ports:
- CLK100MHZ  in  1  system clock; all logic on rising edge
- CPU_RESETN  in  1  synchronous, active-low reset
- rx_ready  in  1  one-cycle strobe: rx_data valid
- rx_data  in  8  received byte
- frame_restart  in  1  synchronous pulse: drop partial pixel, address back to 0
- bram_we  out  1  port-A write enable, one-cycle pulse per pixel
- bram_addr  out  ADDR_W  port-A write address
- bram_din  out  24  pixel, {R,G,B} = {[23:16],[15:8],[7:0]}
- frame_done  out  1  one-cycle pulse with the write of pixel PIXELS-1
- busy  out  1  high while a pixel is partially assembled
- resync_err  out  1  one-cycle pulse when a partial pixel is dropped by timeout

## Operation
- FSM states: WAIT_R, WAIT_G, WAIT_B.
- WAIT_R + rx_ready: latch R, go to WAIT_G.
- WAIT_G + rx_ready: latch G, go to WAIT_B.
- WAIT_B + rx_ready: latch B, go to WAIT_R, schedule the write.
- busy = (state != WAIT_R).
- Write: bram_we=1 for one cycle. bram_addr = current pixel index. bram_din = {R,G,B}.
- Pixel index increments after each write. After index PIXELS-1 it wraps to 0 and frame_done pulses together with that write.
- Timeout: an idle counter clears on every accepted byte and counts while busy. When it reaches TIMEOUT_CYCLES:
  - state goes to WAIT_R, resync_err pulses;
  - pixel index unchanged, no write.
- Counter width is $clog2(TIMEOUT_CYCLES+1). It saturates and is held at 0 in WAIT_R.
- Precedence, highest first: reset, frame_restart, rx_ready, timeout.
  - rx_ready in the same cycle as frame_restart: byte discarded.
  - rx_ready in the same cycle the counter reaches the limit: byte accepted, no resync_err.
- frame_restart in WAIT_R with index already 0: no visible effect.
- Reset values:
  - bram_we=0, bram_addr=0, bram_din=0, frame_done=0, busy=0, resync_err=0;
  - state WAIT_R, idle counter 0.
- Reset mid-pixel drops the partial pixel silently; no resync_err.

## Timing
- rx_ready is a single-cycle pulse. Back-to-back pulses on consecutive cycles must be accepted.
- Latency: bram_we, bram_addr and bram_din are registered. They are valid in the cycle after the clock edge that samples the B byte's rx_ready.
- bram_addr and bram_din hold their values between writes; they change only on a write.
- frame_done and resync_err are registered one-cycle pulses aligned with their triggering event as described above.
- Minimum pixel period is 3 cycles; the write path has no backpressure.

## Structure
- Shared package fb_pkg:
  - FB_ADDR_W, FB_PIXELS, FB_DATA_W=24;
  - typedef rgb_t (packed struct r,g,b of 8 bits);
  - FSM state enum.
  The BRAM readers use the same package.
- One sub-module, byte_timeout: idle counter with clear, enable and terminal pulse, parameterised by TIMEOUT_CYCLES.

## Test plan
- Reset, then bytes 0x12,0x34,0x56 -> one bram_we, addr 0, din 0x123456. Second pixel 0xAA,0xBB,0xCC -> addr 1, din 0xAABBCC. busy high only between the first and third byte.
- PIXELS=4, 12 back-to-back bytes -> writes at addr 0,1,2,3; frame_done with the addr-3 write only. Next pixel writes addr 0.
- TIMEOUT_CYCLES=16: bytes 0x01,0x02, then 16 idle cycles -> resync_err pulse, no write. Then 0x10,0x20,0x30 -> addr 0, din 0x102030.
- rx_ready on the exact cycle the timeout would fire -> byte accepted, no resync_err, pixel completes normally.
- frame_restart after 5 pixels plus 1 byte, with rx_ready high the same cycle -> byte dropped; next 3 bytes write addr 0.
- CPU_RESETN low for 1 cycle mid-pixel at addr 7 -> all outputs 0 the next cycle; next complete pixel writes addr 0.
